// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the inverse-cipher datapath.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL
    } inv_state_e;

    // Fixed InvMixColumns coefficients.
    typedef enum logic [1:0] {
        MUL_09,
        MUL_0B,
        MUL_0D,
        MUL_0E
    } gmul_sel_e;

    // Multiply by {02} modulo x^8 + x^4 + x^3 + x + 1.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply built from an xtime chain; no general multiplier.
    function automatic aes_byte_t gmul_inv(input aes_byte_t b, input gmul_sel_e sel);
        aes_byte_t x2, x4, x8, r;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (sel)
            MUL_09:  r = x8 ^ b;
            MUL_0B:  r = x8 ^ x2 ^ b;
            MUL_0D:  r = x8 ^ x4 ^ b;
            default: r = x8 ^ x4 ^ x2;
        endcase
        return r;
    endfunction

    // Byte 4c+r sits in row r, column c; row r rotates right by r columns.
    function automatic aes_block_t inv_shift_rows(input aes_block_t b);
        aes_block_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[127-8*(4*c+rr) -: 8] = b[127-8*(4*((c+4-rr)%4)+rr) -: 8];
            end
        end
        return r;
    endfunction

    // One column of InvMixColumns; byte 0 of the column is w[31:24].
    function automatic aes_word_t inv_mix_column(input aes_word_t w);
        aes_byte_t a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gmul_inv(a0, MUL_0E) ^ gmul_inv(a1, MUL_0B) ^ gmul_inv(a2, MUL_0D) ^ gmul_inv(a3, MUL_09),
                gmul_inv(a0, MUL_09) ^ gmul_inv(a1, MUL_0E) ^ gmul_inv(a2, MUL_0B) ^ gmul_inv(a3, MUL_0D),
                gmul_inv(a0, MUL_0D) ^ gmul_inv(a1, MUL_09) ^ gmul_inv(a2, MUL_0E) ^ gmul_inv(a3, MUL_0B),
                gmul_inv(a0, MUL_0B) ^ gmul_inv(a1, MUL_0D) ^ gmul_inv(a2, MUL_09) ^ gmul_inv(a3, MUL_0E)};
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box lookup (one byte).
module inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign dout = INV_SBOX[din];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 decryption: one inverse round per clock, 11 cycles per block.
//
// Handshake: start is sampled only while the FSM is IDLE (busy low); an accepted
// start raises busy on the next cycle. done pulses for one cycle as busy drops,
// and plaintext then holds until the next completion. start held high in the
// done cycle is accepted immediately.
module aes_inv_cipher_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] round_key,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);

    import aes_pkg::*;

    inv_state_e fsm_q;
    logic [3:0] cnt_q;
    aes_block_t st_q;

    aes_block_t isr;
    aes_block_t isb;
    aes_block_t mix_in;
    aes_block_t round_out;

    assign isr = inv_shift_rows(st_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .din  (isr[127-8*i -: 8]),
            .dout (isb[127-8*i -: 8])
        );
    end

    // AddRoundKey follows InvSubBytes; the final round uses this value directly.
    assign mix_in = isb ^ round_key;

    // InvMixColumns applied column by column to the keyed round state.
    always_comb begin
        round_out = '0;
        for (int c = 0; c < 4; c++) begin
            round_out[127-32*c -: 32] = inv_mix_column(mix_in[127-32*c -: 32]);
        end
    end

    // Key index decodes from registers only, so the key store sees no input path.
    always_comb begin
        rk_idx = 4'(NR);
        case (fsm_q)
            ST_ROUND: rk_idx = cnt_q;
            ST_FINAL: rk_idx = 4'd0;
            default:  rk_idx = 4'(NR);
        endcase
    end

    // Control FSM, round counter and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= ST_IDLE;
            cnt_q     <= '0;
            st_q      <= '0;
            plaintext <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        st_q  <= ciphertext ^ round_key;
                        cnt_q <= 4'(NR - 1);
                        busy  <= 1'b1;
                        fsm_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    st_q  <= round_out;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        fsm_q <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    plaintext <= mix_in;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    fsm_q     <= ST_IDLE;
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Self-checking bench for aes_inv_cipher_core: encrypt-side reference model,
// scoreboard on done, vector table plus hand-written corner sequences.
module tb_aes_inv_cipher_core;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;

    logic [127:0] rk_tab [0:10];
    logic [7:0]   fsbox [256];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [127:0] exp_q [$];
    int           lat_q [$];
    logic [127:0] cur_exp;
    logic         done_prev;
    logic [127:0] mon_e;
    int           mon_l;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vecs [6];

    // stand-alone S-box instances
    logic [7:0]   sb_in, sb_out;
    logic [127:0] sb_blk_in, sb_blk_out;

    aes_inv_cipher_core #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ciphertext (ciphertext),
        .round_key  (round_key),
        .rk_idx     (rk_idx),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext)
    );

    inv_sbox u_sb (.din(sb_in), .dout(sb_out));

    for (genvar i = 0; i < 16; i++) begin : g_sb_blk
        inv_sbox u_sb_b (.din(sb_blk_in[127-8*i -: 8]), .dout(sb_blk_out[127-8*i -: 8]));
    end

    // asynchronous key store
    assign round_key = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // forward S-box from GF inverse + affine transform
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            fsbox[x] = s;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {fsbox[t[31:24]], fsbox[t[23:16]], fsbox[t[15:8]], fsbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gm(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // forward cipher reference
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = fsbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[4*c+rr] = t[4*((c+rr)%4)+rr];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= rk_tab[r][127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // scoreboard: push on accept, pop and compare on done
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            lat_q.delete();
            done_prev = 1'b0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 128'(done), 128'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_l = lat_q.pop_front();
                    check("plaintext", plaintext, mon_e);
                    check("latency", 128'(cyc - mon_l), 128'(11));
                end
                check("busy_at_done", 128'(busy), 128'(0));
                check("done_width", 128'(done_prev), 128'(0));
            end
            if (start && !busy) begin
                exp_q.push_back(cur_exp);
                lat_q.push_back(cyc);
            end
            done_prev = done;
        end
    end

    task automatic send(input logic [127:0] ct, input logic [127:0] pe);
        @(posedge clk); #1;
        ciphertext = ct;
        cur_exp    = pe;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // returns at the negedge where done is seen, or flags a timeout
    task automatic wait_done(input int bound);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 128'(0), 128'(1));
    endtask

    logic [127:0] c1_ct, c1_pt, last_pt, pa, pb;
    int t1, t2;

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        ciphertext = '0;
        cur_exp    = '0;
        c1_ct      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        c1_pt      = 128'h00112233445566778899aabbccddeeff;
        #1 rst_n = 1'b0;

        build_sbox();
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        check("model_rk10", rk_tab[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("model_encrypt", encrypt(c1_pt), c1_ct);

        // inverse S-box alone
        sb_in = 8'h63; #1 check("sbox_63", 128'(sb_out), 128'(8'h00));
        sb_in = 8'hca; #1 check("sbox_ca", 128'(sb_out), 128'(8'h10));
        sb_in = 8'hb7; #1 check("sbox_b7", 128'(sb_out), 128'(8'h20));
        sb_in = 8'h8c; #1 check("sbox_8c", 128'(sb_out), 128'(8'hf0));
        sb_blk_in = 128'h63cab7040953d051cd60e0e7ba70e18c;
        #1 check("sbox_block", sb_blk_out, 128'h00102030405060708090a0b0c0d0e0f0);

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_plaintext", plaintext, 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(10));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        @(negedge clk) rst_n = 1'b1;

        // FIPS-197 C.1 with rk_idx walk 10..0
        @(posedge clk); #1;
        ciphertext = c1_ct;
        cur_exp    = c1_pt;
        start      = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("rk_idx_%0d", k), 128'(rk_idx), 128'(10 - k));
            if (k == 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        wait_done(5);

        // vector table, with a stray start pulse during each busy window
        vecs[0].pt = c1_pt;
        vecs[0].ct = c1_ct;
        for (int i = 1; i < 6; i++) begin
            vecs[i].pt = rand_block();
            vecs[i].ct = encrypt(vecs[i].pt);
        end
        vecs[5].pt = '1;
        vecs[5].ct = encrypt(vecs[5].pt);
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].ct, vecs[i].pt);
            repeat ($urandom_range(1, 7)) @(posedge clk);
            #1;
            ciphertext = rand_block();
            start      = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(20);
        end

        // back-to-back with start held high
        pa = rand_block();
        pb = rand_block();
        @(posedge clk); #1;
        ciphertext = encrypt(pa);
        cur_exp    = pa;
        start      = 1'b1;
        @(posedge clk); #1;
        ciphertext = encrypt(pb);
        cur_exp    = pb;
        wait_done(15);
        t1 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(15);
        t2 = cyc;
        check("b2b_spacing", 128'(t2 - t1), 128'(11));

        // reset in the middle of a block
        send(vecs[1].ct, vecs[1].pt);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_plaintext", plaintext, 128'(0));
        check("midrst_rk_idx", 128'(rk_idx), 128'(10));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (15) @(posedge clk);
        send(vecs[2].ct, vecs[2].pt);
        wait_done(20);
        last_pt = vecs[2].pt;
        @(posedge clk);

        // idle hold: ciphertext moves, nothing else does
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            ciphertext = rand_block();
            @(negedge clk);
            check("idle_plaintext", plaintext, last_pt);
            check("idle_busy_done", 128'({busy, done}), 128'(0));
        end

        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
